// File: rtl/hsi_vctr_dist_pkg.sv
// Shared types and constants for the vector distance engine.
// Holds the FSM states, the distance mode, the output latency and a log2 helper for the length.
package hsi_vctr_dist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } state_e;

    typedef enum logic {
        MODE_MSE = 1'b0,
        MODE_MAE = 1'b1
    } mode_e;

    // Cycles from the last accepted word to the mse_valid pulse.
    localparam int unsigned OUT_LATENCY  = 5;
    localparam int unsigned DRAIN_CYCLES = OUT_LATENCY - 1;

    // Bit position of the highest set bit; exact log2 for power-of-two lengths.
    function automatic logic [7:0] pow2_log(input logic [31:0] v);
        pow2_log = '0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) pow2_log = 8'(i);
        end
    endfunction

endpackage

// File: rtl/hsi_dist_lane.sv
// One lane of the distance datapath: registered squared/absolute difference (S2)
// followed by a saturating accumulator (S3) that restarts on the first word of a vector.
module hsi_dist_lane
    import hsi_vctr_dist_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int DATA_WIDTH_ACC = 48
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_WIDTH-1:0]     s1_a,
    input  logic [DATA_WIDTH-1:0]     s1_b,
    input  mode_e                     s1_mode,
    input  logic                      s2_valid,
    input  logic                      s2_first,
    output logic [DATA_WIDTH_ACC-1:0] acc
);

    logic [DATA_WIDTH:0]       diff;
    logic [DATA_WIDTH-1:0]     mag;
    logic [2*DATA_WIDTH-1:0]   dist_d;
    logic [2*DATA_WIDTH-1:0]   dist_q;
    logic [DATA_WIDTH_ACC:0]   acc_sum;

    // |a-b| squared equals (a-b) squared, so one unsigned multiplier serves both signs.
    always_comb begin
        diff    = {1'b0, s1_a} - {1'b0, s1_b};
        mag     = diff[DATA_WIDTH] ? (~diff[DATA_WIDTH-1:0] + DATA_WIDTH'(1)) : diff[DATA_WIDTH-1:0];
        dist_d  = (s1_mode == MODE_MAE) ? (2*DATA_WIDTH)'(mag) : mag * mag;
        acc_sum = {1'b0, acc} + (DATA_WIDTH_ACC+1)'(dist_q);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dist_q <= '0;
            acc    <= '0;
        end else begin
            dist_q <= dist_d;
            if (s2_valid) begin
                if (s2_first)                   acc <= DATA_WIDTH_ACC'(dist_q);
                else if (acc_sum[DATA_WIDTH_ACC]) acc <= '1;
                else                            acc <= acc_sum[DATA_WIDTH_ACC-1:0];
            end
        end
    end

endmodule

// File: rtl/hsi_vctr_dist.sv
// Vector distance engine: accumulates per-lane MSE/MAE terms over a power-of-two
// length vector and reports the saturated mean plus the raw total five cycles after the last word.
module hsi_vctr_dist
    import hsi_vctr_dist_pkg::*;
#(
    parameter int WORD_WIDTH     = 32,
    parameter int DATA_WIDTH     = 16,
    parameter int DATA_PER_WORD  = WORD_WIDTH / DATA_WIDTH,
    parameter int DATA_WIDTH_ACC = 48,
    parameter int MAX_ELEMENTS   = 64,
    parameter int ELEMENTS_ADDR  = $clog2(MAX_ELEMENTS)
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              start_vctr,
    input  logic [ELEMENTS_ADDR:0]                            vctr_len,
    input  logic                                              mode,
    input  logic [WORD_WIDTH-1:0]                             element_a,
    input  logic [WORD_WIDTH-1:0]                             element_b,
    input  logic                                              element_valid,
    output logic                                              element_ready,
    output logic [WORD_WIDTH-1:0]                             mse,
    output logic [DATA_WIDTH_ACC+$clog2(DATA_PER_WORD)-1:0]   acc_out,
    output logic                                              mse_valid,
    output logic                                              error
);

    localparam int LOG_DPW = $clog2(DATA_PER_WORD);
    localparam int ACC_W   = DATA_WIDTH_ACC + LOG_DPW;
    localparam logic [ELEMENTS_ADDR:0] LEN_ONE = 1;
    localparam logic [ELEMENTS_ADDR:0] LEN_MAX = MAX_ELEMENTS;

    state_e                    state, state_next;
    logic                      accept, len_ok, take, restart, err_next;
    logic [ELEMENTS_ADDR:0]    len_q, word_cnt;
    logic [7:0]                shift_q;
    logic [1:0]                drain_cnt;
    mode_e                     mode_q;
    logic                      s1_valid, s1_first, s2_valid, s2_first;
    mode_e                     s1_mode;
    logic [WORD_WIDTH-1:0]     s1_a, s1_b;
    logic [DATA_WIDTH_ACC-1:0] lane_acc [DATA_PER_WORD];
    logic [ACC_W-1:0]          tree_sum, s4_sum, shifted;

    assign element_ready = (state == IDLE) || (state == ACCUM);
    assign accept        = element_valid && element_ready;
    assign len_ok        = (vctr_len != '0) && (vctr_len <= LEN_MAX) &&
                           ((vctr_len & (vctr_len - LEN_ONE)) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        take       = 1'b0;
        restart    = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE, ACCUM: begin
                if (accept && start_vctr) begin
                    // A start mid-vector is a protocol error but still begins a fresh vector.
                    err_next = (state == ACCUM) || !len_ok;
                    if (len_ok) begin
                        take       = 1'b1;
                        restart    = 1'b1;
                        state_next = (vctr_len == LEN_ONE) ? DRAIN : ACCUM;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (accept && state == IDLE) begin
                    err_next = 1'b1;
                end else if (accept) begin
                    take = 1'b1;
                    if (word_cnt == len_q - LEN_ONE) state_next = DRAIN;
                end
            end
            DRAIN:   if (drain_cnt == 2'(DRAIN_CYCLES - 1)) state_next = OUTPUT;
            OUTPUT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q     <= '0;
            word_cnt  <= '0;
            shift_q   <= '0;
            mode_q    <= MODE_MSE;
            drain_cnt <= '0;
            error     <= 1'b0;
        end else begin
            error     <= err_next;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            if (restart) begin
                len_q    <= vctr_len;
                word_cnt <= LEN_ONE;
                shift_q  <= pow2_log(32'(vctr_len)) + 8'(LOG_DPW);
                mode_q   <= mode_e'(mode);
            end else if (take) begin
                word_cnt <= word_cnt + LEN_ONE;
            end
        end
    end

    // NOTE: pipeline registers are plain flops, not memories, so they are all async-reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_mode  <= MODE_MSE;
            s1_a     <= '0;
            s1_b     <= '0;
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
        end else begin
            s1_valid <= take;
            s1_first <= restart;
            s2_valid <= s1_valid;
            s2_first <= s1_first;
            if (take) begin
                s1_mode <= restart ? mode_e'(mode) : mode_q;
                s1_a    <= element_a;
                s1_b    <= element_b;
            end
        end
    end

    for (genvar i = 0; i < DATA_PER_WORD; i++) begin : g_lane
        hsi_dist_lane #(
            .DATA_WIDTH     (DATA_WIDTH),
            .DATA_WIDTH_ACC (DATA_WIDTH_ACC)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .s1_a     (s1_a[i*DATA_WIDTH +: DATA_WIDTH]),
            .s1_b     (s1_b[i*DATA_WIDTH +: DATA_WIDTH]),
            .s1_mode  (s1_mode),
            .s2_valid (s2_valid),
            .s2_first (s2_first),
            .acc      (lane_acc[i])
        );
    end

    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < DATA_PER_WORD; i++) tree_sum = tree_sum + ACC_W'(lane_acc[i]);
        shifted = s4_sum >> shift_q;
    end

    // S5 loads only on the last drain cycle so mse/acc_out hold between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s4_sum    <= '0;
            mse       <= '0;
            acc_out   <= '0;
            mse_valid <= 1'b0;
        end else begin
            s4_sum    <= tree_sum;
            mse_valid <= 1'b0;
            if (state == DRAIN && drain_cnt == 2'(DRAIN_CYCLES - 1)) begin
                mse_valid <= 1'b1;
                acc_out   <= s4_sum;
                mse       <= (shifted[ACC_W-1:WORD_WIDTH] != '0) ? '1 : shifted[WORD_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_hsi_vctr_dist.sv
// Directed bench for hsi_vctr_dist: hand-computed vectors for MSE/MAE, boundaries,
// protocol errors, restart and mid-vector reset, plus an 8-bit-lane instance.
module tb_hsi_vctr_dist;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_vctr = 1'b0;
    logic [6:0]  vctr_len = '0;
    logic        mode = 1'b0;
    logic [31:0] element_a = '0;
    logic [31:0] element_b = '0;
    logic        element_valid = 1'b0;
    logic        element_ready;
    logic [31:0] mse;
    logic [48:0] acc_out;
    logic        mse_valid;
    logic        error;

    logic        st8 = 1'b0;
    logic [6:0]  len8 = '0;
    logic        mode8 = 1'b0;
    logic [15:0] a8 = '0;
    logic [15:0] b8 = '0;
    logic        val8 = 1'b0;
    logic        rdy8;
    logic [15:0] mse8;
    logic [48:0] acc8;
    logic        mv8;
    logic        err8;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int vcnt  = 0;
    int ecnt  = 0;
    int last_acc = 0;

    hsi_vctr_dist u_dut (
        .clk (clk), .rst_n (rst_n), .start_vctr (start_vctr), .vctr_len (vctr_len),
        .mode (mode), .element_a (element_a), .element_b (element_b),
        .element_valid (element_valid), .element_ready (element_ready),
        .mse (mse), .acc_out (acc_out), .mse_valid (mse_valid), .error (error)
    );

    hsi_vctr_dist #(.WORD_WIDTH (16), .DATA_WIDTH (8)) u_dut8 (
        .clk (clk), .rst_n (rst_n), .start_vctr (st8), .vctr_len (len8),
        .mode (mode8), .element_a (a8), .element_b (b8),
        .element_valid (val8), .element_ready (rdy8),
        .mse (mse8), .acc_out (acc8), .mse_valid (mv8), .error (err8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mse_valid === 1'b1) vcnt <= vcnt + 1;
        if (error === 1'b1)     ecnt <= ecnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic st, input logic [6:0] len, input logic md,
                             input logic [31:0] a, input logic [31:0] b);
        element_valid = 1'b1;
        start_vctr    = st;
        vctr_len      = len;
        mode          = md;
        element_a     = a;
        element_b     = b;
        @(posedge clk);
        #1;
        last_acc      = cyc;
        element_valid = 1'b0;
        start_vctr    = 1'b0;
    endtask

    // The pulse is set by the 4th edge after the accepting edge, i.e. it is high in cycle t+5.
    task automatic wait_output(input string tag, input logic [63:0] exp_acc, input logic [63:0] exp_mse);
        int k;
        check({tag, "/ready_drain"}, 64'(element_ready), 64'd0);
        k = 0;
        while (mse_valid !== 1'b1 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "/valid"}, 64'(mse_valid), 64'd1);
        check({tag, "/latency"}, 64'(cyc - last_acc), 64'd4);
        check({tag, "/ready_out"}, 64'(element_ready), 64'd0);
        check({tag, "/acc_out"}, 64'(acc_out), exp_acc);
        check({tag, "/mse"}, 64'(mse), exp_mse);
        @(posedge clk);
        #1;
        check({tag, "/pulse_end"}, 64'(mse_valid), 64'd0);
        check({tag, "/ready_idle"}, 64'(element_ready), 64'd1);
        check({tag, "/mse_hold"}, 64'(mse), exp_mse);
    endtask

    task automatic run_vector(input string tag, input logic [6:0] len, input logic md,
                              input logic [31:0] a, input logic [31:0] b, input bit gaps,
                              input logic [63:0] exp_acc, input logic [63:0] exp_mse);
        int v0;
        v0 = vcnt;
        for (int i = 0; i < int'(len); i++) begin
            if (gaps && (i % 5 == 2)) begin
                @(posedge clk);
                #1;
            end
            send_word(i == 0, len, md, a, b);
        end
        wait_output(tag, exp_acc, exp_mse);
        check({tag, "/one_pulse"}, 64'(vcnt - v0), 64'd1);
    endtask

    initial begin
        int e0, v0, k;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset/ready", 64'(element_ready), 64'd1);
        check("reset/mse_valid", 64'(mse_valid), 64'd0);
        check("reset/error", 64'(error), 64'd0);
        check("reset/mse", 64'(mse), 64'd0);
        check("reset/acc_out", 64'(acc_out), 64'd0);

        // 2 lanes * 64 words * 3^2 = 1152; shift by 6+1 -> 9. Gaps must not matter.
        run_vector("mse_10_7", 7'd64, 1'b0, {16'd10, 16'd10}, {16'd7, 16'd7}, 1'b1, 64'd1152, 64'd9);
        // 2 * 64 * 3 = 384 -> 3.
        run_vector("mae_10_7", 7'd64, 1'b1, {16'd10, 16'd10}, {16'd7, 16'd7}, 1'b0, 64'd384, 64'd3);
        // 128 * 0xFFFE0001 = 0x7FFF000080 -> 0xFFFE0001, just under saturation.
        run_vector("mse_full", 7'd64, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 64'h7F_FF00_0080, 64'hFFFE_0001);
        // Lane0 100-90 -> 100, lane1 3-8 -> 25; 2 words -> 250, shift 2 -> 62.
        run_vector("mse_mixed", 7'd2, 1'b0, {16'd3, 16'd100}, {16'd8, 16'd90}, 1'b0, 64'd250, 64'd62);
        // Single word, MAE: 65535 + 1 = 65536, shift 0+1 -> 32768.
        run_vector("mae_len1", 7'd1, 1'b1, {16'd1, 16'd0}, {16'd0, 16'hFFFF}, 1'b0, 64'd65536, 64'd32768);

        // Illegal length: error, stays ready, nothing produced.
        e0 = ecnt;
        v0 = vcnt;
        send_word(1'b1, 7'd3, 1'b0, 32'h1, 32'h0);
        check("len3/ready", 64'(element_ready), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        check("len3/error", 64'(ecnt - e0), 64'd1);
        check("len3/no_valid", 64'(vcnt - v0), 64'd0);

        // Element without start while idle is rejected with an error.
        e0 = ecnt;
        send_word(1'b0, 7'd4, 1'b0, 32'h5, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        check("idle_nostart/error", 64'(ecnt - e0), 64'd1);
        check("idle_nostart/ready", 64'(element_ready), 64'd1);

        // Restart at word 20: new len-4 vector, diff 4 -> 4*2*16 = 128, shift 3 -> 16.
        e0 = ecnt;
        v0 = vcnt;
        for (int i = 0; i < 20; i++) send_word(i == 0, 7'd64, 1'b0, {16'd10, 16'd10}, {16'd7, 16'd7});
        for (int i = 0; i < 4; i++) send_word(i == 0, 7'd4, 1'b0, {16'd5, 16'd5}, {16'd1, 16'd1});
        wait_output("restart", 64'd128, 64'd16);
        check("restart/error", 64'(ecnt - e0), 64'd1);
        check("restart/one_pulse", 64'(vcnt - v0), 64'd1);

        // Reset at word 30 discards the partial vector.
        v0 = vcnt;
        for (int i = 0; i < 30; i++) send_word(i == 0, 7'd64, 1'b0, {16'd9, 16'd9}, {16'd1, 16'd1});
        rst_n = 1'b0;
        #1;
        check("midreset/mse_cleared", 64'(mse), 64'd0);
        check("midreset/acc_cleared", 64'(acc_out), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midreset/ready", 64'(element_ready), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        check("midreset/no_valid", 64'(vcnt - v0), 64'd0);
        run_vector("after_reset", 7'd64, 1'b0, {16'd10, 16'd10}, {16'd7, 16'd7}, 1'b0, 64'd1152, 64'd9);

        // 8-bit lanes: 128 * 0xFE01 = 0x7F0080 -> 0xFE01.
        for (int i = 0; i < 64; i++) begin
            val8 = 1'b1;
            st8  = (i == 0);
            len8 = 7'd64;
            a8   = 16'hFFFF;
            b8   = 16'h0000;
            @(posedge clk);
            #1;
        end
        val8 = 1'b0;
        st8  = 1'b0;
        k = 0;
        while (mv8 !== 1'b1 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("w16/valid", 64'(mv8), 64'd1);
        check("w16/latency_edges", 64'(k), 64'd4);
        check("w16/mse", 64'(mse8), 64'hFE01);
        check("w16/acc_out", 64'(acc8), 64'h7F_0080);
        check("w16/error", 64'(err8), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
